// File: rtl/frame_capture_writer.sv
// Camera byte stream to RGB565 frame-buffer writer with per-frame integrity report.
// Optional FRAME_SKIP_EN: capture only every other frame (odd frames pass through silently).
`timescale 1ns/1ps

module frame_capture_writer #(
    parameter int IMAGE_WIDTH  = 320,
    parameter int IMAGE_HEIGHT = 240,
    parameter int ADDR_BITS    = $clog2(IMAGE_WIDTH*IMAGE_HEIGHT)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 vsync,
    input  logic                 href,
    input  logic                 pix_valid,
    input  logic [7:0]           pix_data,
    output logic [ADDR_BITS-1:0] wraddress,
    output logic [15:0]          wrdata,
    output logic                 wren,
    output logic                 frame_done,
    output logic                 frame_ok
);

    localparam int COL_BITS = $clog2(IMAGE_WIDTH + 1);
    localparam int ROW_BITS = $clog2(IMAGE_HEIGHT + 2);

    localparam logic [COL_BITS-1:0]  COL_FULL  = COL_BITS'(IMAGE_WIDTH);
    localparam logic [ROW_BITS-1:0]  ROW_FULL  = ROW_BITS'(IMAGE_HEIGHT);
    localparam logic [ROW_BITS-1:0]  ROW_LAST  = ROW_BITS'(IMAGE_HEIGHT - 1);
    localparam logic [ROW_BITS-1:0]  ROW_SAT   = ROW_BITS'(IMAGE_HEIGHT + 1);
    localparam logic [ADDR_BITS-1:0] LINE_STEP = ADDR_BITS'(IMAGE_WIDTH);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_SYNC    = 2'd1;
    localparam logic [1:0] ST_CAPTURE = 2'd2;

    logic [1:0]           state, state_n;
    logic                 vsync_q, href_q;
    logic [COL_BITS-1:0]  col, col_n;
    logic [ROW_BITS-1:0]  row, row_n;
    logic [ADDR_BITS-1:0] line_base, line_base_n;
    logic                 phase, phase_n;
    logic [7:0]           hi_byte, hi_byte_n;
    logic                 err, err_n;
    logic [ADDR_BITS-1:0] wraddress_n;
    logic [15:0]          wrdata_n;
    logic                 wren_n, frame_done_n, frame_ok_n;
    logic                 capture_en;

    logic vsync_rise, vsync_fall, href_fall, frame_end;
    assign vsync_rise = vsync & ~vsync_q;
    assign vsync_fall = ~vsync & vsync_q;
    assign href_fall  = ~href & href_q;
    assign frame_end  = (state == ST_CAPTURE) && vsync_rise;

`ifdef FRAME_SKIP_EN
    logic odd_frame;
    assign capture_en = ~odd_frame;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            odd_frame <= 1'b0;
        else if (frame_end)
            odd_frame <= ~odd_frame;
    end
`else
    assign capture_en = 1'b1;
`endif

    // Within one cycle the order is: pixel pairing, line close, frame end.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latch).
        state_n      = state;
        col_n        = col;
        row_n        = row;
        line_base_n  = line_base;
        phase_n      = phase;
        hi_byte_n    = hi_byte;
        err_n        = err;
        wraddress_n  = wraddress;
        wrdata_n     = wrdata;
        wren_n       = 1'b0;
        frame_done_n = 1'b0;
        frame_ok_n   = frame_ok;

        case (state)
            ST_IDLE: begin
                if (vsync_rise)
                    state_n = ST_SYNC;
            end

            ST_SYNC: begin
                if (vsync_fall) begin
                    state_n     = ST_CAPTURE;
                    col_n       = '0;
                    row_n       = '0;
                    line_base_n = '0;
                    phase_n     = 1'b0;
                    err_n       = 1'b0;
                end
            end

            ST_CAPTURE: begin
                if (pix_valid && href) begin
                    if (!phase) begin
                        hi_byte_n = pix_data;
                        phase_n   = 1'b1;
                    end else begin
                        phase_n = 1'b0;
                        if (col < COL_FULL && row < ROW_FULL) begin
                            wren_n      = capture_en;
                            wraddress_n = line_base + ADDR_BITS'(col);
                            wrdata_n    = {hi_byte, pix_data};
                            col_n       = col + 1'b1;
                        end else begin
                            err_n = 1'b1;
                        end
                    end
                end

                if (href_fall) begin
                    if (col != '0) begin
                        if (row != ROW_SAT)
                            row_n = row + 1'b1;
                        // Base stops at the last stored line so it never leaves the buffer.
                        if (row < ROW_LAST)
                            line_base_n = line_base + LINE_STEP;
                    end
                    if (col != COL_FULL || phase)
                        err_n = 1'b1;
                    col_n   = '0;
                    phase_n = 1'b0;
                end

                if (vsync_rise) begin
                    if (col_n != '0 || phase_n)
                        err_n = 1'b1;
                    col_n   = '0;
                    phase_n = 1'b0;
                    state_n = ST_SYNC;
                    if (capture_en) begin
                        frame_done_n = 1'b1;
                        frame_ok_n   = (row_n == ROW_FULL) && !err_n;
                    end
                end
            end

            default: state_n = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            vsync_q    <= 1'b0;
            href_q     <= 1'b0;
            col        <= '0;
            row        <= '0;
            line_base  <= '0;
            phase      <= 1'b0;
            hi_byte    <= '0;
            err        <= 1'b0;
            wraddress  <= '0;
            wrdata     <= '0;
            wren       <= 1'b0;
            frame_done <= 1'b0;
            frame_ok   <= 1'b0;
        end else begin
            state      <= state_n;
            vsync_q    <= vsync;
            href_q     <= href;
            col        <= col_n;
            row        <= row_n;
            line_base  <= line_base_n;
            phase      <= phase_n;
            hi_byte    <= hi_byte_n;
            err        <= err_n;
            wraddress  <= wraddress_n;
            wrdata     <= wrdata_n;
            wren       <= wren_n;
            frame_done <= frame_done_n;
            frame_ok   <= frame_ok_n;
        end
    end

endmodule

// File: tb/tb_frame_capture_writer.sv
// Self-checking bench for frame_capture_writer (W=4, H=3) against a frame-level reference model.
`timescale 1ns/1ps

module tb_frame_capture_writer;

    localparam int W  = 4;
    localparam int H  = 3;
    localparam int AB = $clog2(W*H);
`ifdef FRAME_SKIP_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          vsync = 1'b0;
    logic          href = 1'b0;
    logic          pix_valid = 1'b0;
    logic [7:0]    pix_data = 8'h00;
    logic [AB-1:0] wraddress;
    logic [15:0]   wrdata;
    logic          wren;
    logic          frame_done;
    logic          frame_ok;

    frame_capture_writer #(
        .IMAGE_WIDTH (W),
        .IMAGE_HEIGHT(H),
        .ADDR_BITS   (AB)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .vsync     (vsync),
        .href      (href),
        .pix_valid (pix_valid),
        .pix_data  (pix_data),
        .wraddress (wraddress),
        .wrdata    (wrdata),
        .wren      (wren),
        .frame_done(frame_done),
        .frame_ok  (frame_ok)
    );

    always #10 clk = ~clk;

    typedef struct {
        int addr;
        int data;
        int cyc;
    } wr_t;

    wr_t  act_q[$];
    wr_t  exp_q[$];
    int   line_len[$];
    int   cyc = 0;
    int   done_cnt = 0;
    logic last_ok = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;
    int   frame_parity = 0;
    int   seq_byte = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (wren) begin
            wr_t w;
            w.addr = int'(wraddress);
            w.data = int'(wrdata);
            w.cyc  = cyc;
            act_q.push_back(w);
        end
        if (frame_done) begin
            done_cnt++;
            last_ok = frame_ok;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive_byte(input logic [7:0] b, output int strobe_cyc);
        pix_data   = b;
        pix_valid  = 1'b1;
        strobe_cyc = cyc;
        tick(1);
        pix_valid = 1'b0;
        tick($urandom_range(0, 2));
    endtask

    // Drives one frame of line_len lines and checks writes, latency, frame_done and frame_ok.
    task automatic run_frame(input string name, input bit rand_data);
        bit         capture;
        bit         exp_ok;
        int         row;
        int         sc;
        int         n;
        logic [7:0] b;
        logic [7:0] hi;
        wr_t        e;

        capture = !SKIP || (frame_parity == 0);
        act_q.delete();
        exp_q.delete();
        done_cnt = 0;
        hi = 8'h00;

        vsync = 1'b1;
        tick(3);
        vsync = 1'b0;
        tick(2);

        row    = 0;
        exp_ok = (line_len.size() == H);
        foreach (line_len[l]) begin
            href = 1'b1;
            tick(1);
            for (int i = 0; i < line_len[l]; i++) begin
                b = rand_data ? 8'($urandom_range(0, 255)) : 8'(seq_byte);
                seq_byte++;
                drive_byte(b, sc);
                if (i % 2 == 0) begin
                    hi = b;
                end else if (capture && (i / 2) < W && row < H) begin
                    e.addr = row * W + i / 2;
                    e.data = {16'h0000, hi, b};
                    e.cyc  = sc + 1;
                    exp_q.push_back(e);
                end
            end
            tick(1);
            href = 1'b0;
            if (line_len[l] >= 2) row++;
            if (line_len[l] != 2 * W) exp_ok = 1'b0;
            tick(2);
        end

        vsync = 1'b1;
        tick(4);
        if (SKIP) frame_parity ^= 1;

        n_cmp++;
        if (act_q.size() != exp_q.size()) begin
            n_err++;
            $display("FAIL %s write_count: got %0d expected %0d", name, act_q.size(), exp_q.size());
        end
        n = (act_q.size() < exp_q.size()) ? act_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            n_cmp++;
            if (act_q[i].addr !== exp_q[i].addr || act_q[i].data !== exp_q[i].data ||
                act_q[i].cyc !== exp_q[i].cyc) begin
                n_err++;
                $display("FAIL %s write[%0d]: got addr=%0d data=%04h cyc=%0d expected addr=%0d data=%04h cyc=%0d",
                         name, i, act_q[i].addr, act_q[i].data, act_q[i].cyc,
                         exp_q[i].addr, exp_q[i].data, exp_q[i].cyc);
            end
        end
        n_cmp++;
        if (done_cnt != (capture ? 1 : 0)) begin
            n_err++;
            $display("FAIL %s frame_done_count: got %0d expected %0d", name, done_cnt, capture ? 1 : 0);
        end
        if (capture) begin
            n_cmp++;
            if (last_ok !== exp_ok) begin
                n_err++;
                $display("FAIL %s frame_ok: got %0b expected %0b", name, last_ok, exp_ok);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #5;
        n_cmp++;
        if ({wraddress, wrdata, wren, frame_done, frame_ok} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: got addr=%0d data=%04h wren=%0b done=%0b ok=%0b expected all 0",
                     wraddress, wrdata, wren, frame_done, frame_ok);
        end
        tick(2);
        rst_n = 1'b1;
        tick(2);
        n_cmp++;
        if (wren !== 1'b0 || frame_done !== 1'b0) begin
            n_err++;
            $display("FAIL reset_idle: got wren=%0b done=%0b expected 0 0", wren, frame_done);
        end
    endtask

    task automatic test_clean_frame();
        seq_byte = 0;
        line_len = '{8, 8, 8};
        run_frame("clean_frame", 1'b0);
        n_cmp++;
        if (act_q.size() != 12 || act_q[0].data !== 16'h0001 || act_q[11].data !== 16'h1617 ||
            act_q[11].addr !== 11) begin
            n_err++;
            $display("FAIL clean_frame_ends: got count=%0d expected count=12 first=0001 last=1617@11",
                     act_q.size());
        end
    endtask

    task automatic test_reset_midline();
        int sc;
        rst_n = 1'b0;
        vsync = 1'b0;
        href  = 1'b1;
        tick(2);
        rst_n = 1'b1;
        frame_parity = 0;
        act_q.delete();
        done_cnt = 0;
        for (int i = 0; i < 6; i++) drive_byte(8'($urandom_range(0, 255)), sc);
        href = 1'b0;
        tick(2);
        href = 1'b1;
        for (int i = 0; i < 8; i++) drive_byte(8'($urandom_range(0, 255)), sc);
        href = 1'b0;
        tick(3);
        n_cmp++;
        if (act_q.size() != 0 || done_cnt != 0) begin
            n_err++;
            $display("FAIL reset_midline_quiet: got writes=%0d done=%0d expected 0 0", act_q.size(), done_cnt);
        end
        seq_byte = 0;
        line_len = '{8, 8, 8};
        run_frame("post_reset_frame", 1'b0);
    endtask

    task automatic test_long_line();
        line_len = '{10, 8, 8};
        run_frame("long_line", 1'b1);
    endtask

    task automatic test_odd_line();
        line_len = '{7, 8, 8};
        run_frame("odd_line", 1'b1);
    endtask

    task automatic test_reset_midframe();
        int sc;
        line_len = '{8, 8, 8};
        run_frame("pre_reset_frame", 1'b1);
        if (SKIP && frame_parity == 1) run_frame("pre_reset_skipped", 1'b1);
        act_q.delete();
        done_cnt = 0;
        vsync = 1'b1;
        tick(3);
        vsync = 1'b0;
        tick(2);
        href = 1'b1;
        tick(1);
        for (int i = 0; i < 8; i++) drive_byte(8'($urandom_range(0, 255)), sc);
        tick(1);
        href = 1'b0;
        tick(2);
        href = 1'b1;
        tick(1);
        for (int i = 0; i < 3; i++) drive_byte(8'($urandom_range(0, 255)), sc);
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({wraddress, wrdata, wren, frame_done, frame_ok} !== '0) begin
            n_err++;
            $display("FAIL midframe_reset_outputs: got addr=%0d data=%04h wren=%0b done=%0b ok=%0b expected all 0",
                     wraddress, wrdata, wren, frame_done, frame_ok);
        end
        n_cmp++;
        if (act_q.size() != 5) begin
            n_err++;
            $display("FAIL midframe_partial_writes: got %0d expected 5", act_q.size());
        end
        tick(2);
        href  = 1'b0;
        rst_n = 1'b1;
        frame_parity = 0;
        tick(2);
        vsync = 1'b1;
        tick(4);
        n_cmp++;
        if (done_cnt != 0) begin
            n_err++;
            $display("FAIL midframe_no_done: got %0d expected 0", done_cnt);
        end
        line_len = '{8, 8, 8};
        run_frame("post_midframe_reset", 1'b1);
    endtask

    task automatic test_back_to_back();
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        frame_parity = 0;
        line_len = '{8, 8, 8};
        for (int f = 0; f < 4; f++) run_frame($sformatf("back_to_back_%0d", f), 1'b0);
    endtask

    task automatic test_random_frames();
        int nl;
        for (int f = 0; f < 8; f++) begin
            nl = ($urandom_range(0, 1) == 1) ? H : $urandom_range(2, 4);
            line_len.delete();
            for (int l = 0; l < nl; l++)
                line_len.push_back(($urandom_range(0, 2) == 0) ? $urandom_range(0, 11) : 2 * W);
            run_frame($sformatf("random_%0d", f), 1'b1);
        end
    endtask

    initial begin
        test_reset();
        test_clean_frame();
        test_reset_midline();
        test_long_line();
        test_odd_line();
        test_reset_midframe();
        test_back_to_back();
        test_random_frames();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
